// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the pipelined MIPS core: decoded control bundle
// and the decode->execute latch contents.
package cpu_types_pkg;

  localparam int CPU_WORD_W = 32;
  localparam int CPU_REG_W  = 5;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;

  typedef struct packed {
    aluop_t aluop;
    logic   alusrc;
    logic   regwen;
    logic   dren;
    logic   dwen;
    logic   memtoreg;
    logic   halt;
  } ctrl_t;

  typedef struct packed {
    logic                  valid;
    ctrl_t                 ctrl;
    logic [CPU_REG_W-1:0]  rsel1;
    logic [CPU_REG_W-1:0]  rsel2;
    logic [CPU_REG_W-1:0]  wsel;
    logic [CPU_WORD_W-1:0] rdat1;
    logic [CPU_WORD_W-1:0] rdat2;
    logic [CPU_WORD_W-1:0] imm;
    logic [CPU_WORD_W-1:0] npc;
  } id_ex_t;

  // All-zero so a bubble presents wsel=0 and cannot raise a false hazard.
  localparam id_ex_t BUBBLE_ID_EX = '0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_latch.sv
// Decode->execute pipeline register with flush/load-use bubbles, same-cycle
// writeback bypass on capture, global freeze and a saturating bubble counter.
module id_ex_latch
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = CPU_WORD_W,
  parameter int REG_W  = CPU_REG_W,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              flush,
  input  logic              hazard_dec,
  input  logic [1:0]        rport_dec,
  input  logic [WORD_W-1:0] wdat_mem,
  input  logic              d_valid,
  input  ctrl_t             d_ctrl,
  input  logic [REG_W-1:0]  d_rsel1,
  input  logic [REG_W-1:0]  d_rsel2,
  input  logic [REG_W-1:0]  d_wsel,
  input  logic [WORD_W-1:0] d_rdat1,
  input  logic [WORD_W-1:0] d_rdat2,
  input  logic [WORD_W-1:0] d_imm,
  input  logic [WORD_W-1:0] d_npc,
  output logic              e_valid,
  output ctrl_t             e_ctrl,
  output logic [REG_W-1:0]  e_rsel1,
  output logic [REG_W-1:0]  e_rsel2,
  output logic [REG_W-1:0]  e_wsel,
  output logic [WORD_W-1:0] e_rdat1,
  output logic [WORD_W-1:0] e_rdat2,
  output logic [WORD_W-1:0] e_imm,
  output logic [WORD_W-1:0] e_npc,
  output logic [CNT_W-1:0]  bubble_cnt
);

  id_ex_t ex_q;
  id_ex_t ex_nxt;
  logic   bubble;
  logic   bubble_inc;

  assign bubble = flush | hazard_dec;

  // Flushing an already-empty slot loses nothing, so it is not counted.
  assign bubble_inc = en & bubble & (d_valid | hazard_dec);

  always_comb begin
    ex_nxt = BUBBLE_ID_EX;
    if (!bubble) begin
      ex_nxt.valid = d_valid;
      ex_nxt.ctrl  = d_ctrl;
      ex_nxt.rsel1 = d_rsel1;
      ex_nxt.rsel2 = d_rsel2;
      ex_nxt.wsel  = d_wsel;
      ex_nxt.rdat1 = rport_dec[0] ? wdat_mem : d_rdat1;
      ex_nxt.rdat2 = rport_dec[1] ? wdat_mem : d_rdat2;
      ex_nxt.imm   = d_imm;
      ex_nxt.npc   = d_npc;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ex_q <= BUBBLE_ID_EX;
    end else if (en) begin
      ex_q <= ex_nxt;
    end
  end

  assign e_valid = ex_q.valid;
  assign e_ctrl  = ex_q.ctrl;
  assign e_rsel1 = ex_q.rsel1;
  assign e_rsel2 = ex_q.rsel2;
  assign e_wsel  = ex_q.wsel;
  assign e_rdat1 = ex_q.rdat1;
  assign e_rdat2 = ex_q.rdat2;
  assign e_imm   = ex_q.imm;
  assign e_npc   = ex_q.npc;

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (bubble_inc),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_id_ex_latch.sv
// Randomized and directed bench for id_ex_latch against a field-level
// reference model of the execute slot and bubble count.
module tb_id_ex_latch;
  import cpu_types_pkg::*;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int BW = 1 + 10 + 3*REG_W + 4*WORD_W;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              en, flush, hazard_dec, d_valid;
  logic [1:0]        rport_dec;
  logic [WORD_W-1:0] wdat_mem, d_rdat1, d_rdat2, d_imm, d_npc;
  ctrl_t             d_ctrl;
  logic [REG_W-1:0]  d_rsel1, d_rsel2, d_wsel;
  logic              e_valid;
  ctrl_t             e_ctrl;
  logic [REG_W-1:0]  e_rsel1, e_rsel2, e_wsel;
  logic [WORD_W-1:0] e_rdat1, e_rdat2, e_imm, e_npc;
  logic [CNT_W-1:0]  bubble_cnt;

  id_ex_latch #(.WORD_W(WORD_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .hazard_dec(hazard_dec),
    .rport_dec(rport_dec), .wdat_mem(wdat_mem), .d_valid(d_valid), .d_ctrl(d_ctrl),
    .d_rsel1(d_rsel1), .d_rsel2(d_rsel2), .d_wsel(d_wsel),
    .d_rdat1(d_rdat1), .d_rdat2(d_rdat2), .d_imm(d_imm), .d_npc(d_npc),
    .e_valid(e_valid), .e_ctrl(e_ctrl), .e_rsel1(e_rsel1), .e_rsel2(e_rsel2),
    .e_wsel(e_wsel), .e_rdat1(e_rdat1), .e_rdat2(e_rdat2), .e_imm(e_imm),
    .e_npc(e_npc), .bubble_cnt(bubble_cnt)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model: what the execute slot should hold, field by field.
  logic              m_valid;
  logic [9:0]        m_ctrl;
  logic [REG_W-1:0]  m_rsel1, m_rsel2, m_wsel;
  logic [WORD_W-1:0] m_rdat1, m_rdat2, m_imm, m_npc;
  int                m_cnt;

  wire [BW-1:0] obs = {e_valid, e_ctrl, e_rsel1, e_rsel2, e_wsel, e_rdat1, e_rdat2, e_imm, e_npc};

  function automatic logic [BW-1:0] expb();
    return {m_valid, m_ctrl, m_rsel1, m_rsel2, m_wsel, m_rdat1, m_rdat2, m_imm, m_npc};
  endfunction

  task automatic model_clear();
    m_valid = 0; m_ctrl = '0; m_rsel1 = '0; m_rsel2 = '0; m_wsel = '0;
    m_rdat1 = '0; m_rdat2 = '0; m_imm = '0; m_npc = '0;
  endtask

  task automatic model_reset();
    model_clear();
    m_cnt = 0;
  endtask

  // Apply one rising edge to the model using the currently driven inputs.
  task automatic model_edge();
    if (!en) return;
    if (flush || hazard_dec) begin
      model_clear();
      if ((d_valid || hazard_dec) && m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m_valid = d_valid; m_ctrl = d_ctrl;
      m_rsel1 = d_rsel1; m_rsel2 = d_rsel2; m_wsel = d_wsel;
      m_rdat1 = rport_dec[0] ? wdat_mem : d_rdat1;
      m_rdat2 = rport_dec[1] ? wdat_mem : d_rdat2;
      m_imm = d_imm; m_npc = d_npc;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_idle();
    en = 1; flush = 0; hazard_dec = 0; rport_dec = 2'b00; wdat_mem = '0;
    d_valid = 0; d_ctrl = '0; d_rsel1 = '0; d_rsel2 = '0; d_wsel = '0;
    d_rdat1 = '0; d_rdat2 = '0; d_imm = '0; d_npc = '0;
  endtask

  task automatic drive_random_instr();
    logic [9:0] c;
    c = 10'($urandom);
    d_valid = 1; d_ctrl = c;
    d_rsel1 = REG_W'($urandom); d_rsel2 = REG_W'($urandom); d_wsel = REG_W'($urandom);
    d_rdat1 = $urandom; d_rdat2 = $urandom; d_imm = $urandom; d_npc = $urandom;
    wdat_mem = $urandom;
  endtask

  task automatic test_reset();
    drive_idle();
    nRST = 0; model_reset();
    #2;
    checks++;
    if (obs !== '0 || bubble_cnt !== '0) begin
      errors++; $display("FAIL reset_init: obs=%h cnt=%0d required 0/0", obs, bubble_cnt);
    end
    @(negedge CLK); nRST = 1;
    drive_random_instr();
    d_ctrl.regwen = 1;
    cycle();
    checks++;
    if (e_valid !== 1'b1 || obs !== expb()) begin
      errors++; $display("FAIL reset_prefill: obs=%h required %h", obs, expb());
    end
    hazard_dec = 1; cycle(); hazard_dec = 0;
    drive_random_instr(); cycle();
    #2 nRST = 0; model_reset();
    #1;
    checks++;
    if (obs !== '0 || bubble_cnt !== '0) begin
      errors++; $display("FAIL reset_async: obs=%h cnt=%0d required 0/0", obs, bubble_cnt);
    end
    @(negedge CLK); nRST = 1;
    drive_idle();
  endtask

  task automatic test_capture();
    drive_idle();
    d_valid = 1; d_rdat1 = 32'h1234; d_wsel = 5; d_npc = 32'h40; d_imm = 32'hFFFF_FFF0;
    cycle();
    checks++;
    if (e_rdat1 !== 32'h1234 || e_wsel !== 5'd5 || e_valid !== 1'b1) begin
      errors++; $display("FAIL capture: rdat1=%h wsel=%0d valid=%b required 1234/5/1", e_rdat1, e_wsel, e_valid);
    end
    checks++;
    if (obs !== expb()) begin
      errors++; $display("FAIL capture_all: obs=%h required %h", obs, expb());
    end
  endtask

  task automatic test_load_use();
    int c0;
    c0 = int'(bubble_cnt);
    drive_random_instr(); d_ctrl.regwen = 1; d_wsel = 5'd9;
    hazard_dec = 1;
    cycle();
    checks++;
    if (e_valid !== 0 || e_wsel !== 0 || e_ctrl.regwen !== 0 || int'(bubble_cnt) != c0 + 1) begin
      errors++; $display("FAIL load_use_bubble: valid=%b wsel=%0d regwen=%b cnt=%0d required 0/0/0/%0d",
                         e_valid, e_wsel, e_ctrl.regwen, bubble_cnt, c0 + 1);
    end
    hazard_dec = 0;
    cycle();
    checks++;
    if (e_valid !== 1 || e_wsel !== 5'd9 || obs !== expb() || int'(bubble_cnt) != c0 + 1) begin
      errors++; $display("FAIL load_use_resume: obs=%h cnt=%0d required %h/%0d", obs, bubble_cnt, expb(), c0 + 1);
    end
  endtask

  task automatic test_bypass();
    drive_idle();
    d_valid = 1; d_rdat1 = 1; d_rdat2 = 2; wdat_mem = 32'hDEADBEEF; rport_dec = 2'b11;
    cycle();
    checks++;
    if (e_rdat1 !== 32'hDEADBEEF || e_rdat2 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL bypass_both: rdat1=%h rdat2=%h required deadbeef/deadbeef", e_rdat1, e_rdat2);
    end
    rport_dec = 2'b01;
    cycle();
    checks++;
    if (e_rdat1 !== 32'hDEADBEEF || e_rdat2 !== 32'd2) begin
      errors++; $display("FAIL bypass_op1: rdat1=%h rdat2=%h required deadbeef/2", e_rdat1, e_rdat2);
    end
    rport_dec = 2'b10;
    cycle();
    checks++;
    if (e_rdat1 !== 32'd1 || e_rdat2 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL bypass_op2: rdat1=%h rdat2=%h required 1/deadbeef", e_rdat1, e_rdat2);
    end
  endtask

  task automatic test_freeze();
    logic [BW-1:0] held;
    logic [CNT_W-1:0] hcnt;
    drive_random_instr(); cycle();
    held = obs; hcnt = bubble_cnt;
    drive_random_instr();
    en = 0; flush = 1; hazard_dec = 1; rport_dec = 2'b11;
    cycle(); cycle();
    checks++;
    if (obs !== held || bubble_cnt !== hcnt) begin
      errors++; $display("FAIL freeze_hold: obs=%h cnt=%0d required %h/%0d", obs, bubble_cnt, held, hcnt);
    end
    en = 1;
    cycle();
    checks++;
    if (obs !== '0 || int'(bubble_cnt) != int'(hcnt) + 1) begin
      errors++; $display("FAIL freeze_release: obs=%h cnt=%0d required 0/%0d", obs, bubble_cnt, int'(hcnt) + 1);
    end
    drive_idle(); flush = 1;
    cycle();
    checks++;
    if (int'(bubble_cnt) != int'(hcnt) + 1) begin
      errors++; $display("FAIL flush_invalid_nocount: cnt=%0d required %0d", bubble_cnt, int'(hcnt) + 1);
    end
    flush = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_random_instr();
      d_valid    = ($urandom_range(0, 3) != 0);
      en         = ($urandom_range(0, 4) != 0);
      flush      = ($urandom_range(0, 5) == 0);
      hazard_dec = ($urandom_range(0, 5) == 0);
      rport_dec  = 2'($urandom);
      cycle();
      checks++;
      if (obs !== expb() || int'(bubble_cnt) != m_cnt) begin
        errors++; $display("FAIL random[%0d]: obs=%h cnt=%0d required %h/%0d", i, obs, bubble_cnt, expb(), m_cnt);
      end
    end
    drive_idle();
  endtask

  task automatic test_saturation();
    int n;
    drive_random_instr();
    hazard_dec = 1;
    n = CNT_MAX - m_cnt;
    for (int i = 0; i < n; i++) cycle();
    checks++;
    if (int'(bubble_cnt) != CNT_MAX) begin
      errors++; $display("FAIL sat_reach: cnt=%0d required %0d", bubble_cnt, CNT_MAX);
    end
    for (int i = 0; i < 4; i++) cycle();
    checks++;
    if (bubble_cnt !== 16'hFFFF || int'(bubble_cnt) != m_cnt) begin
      errors++; $display("FAIL sat_nowrap: cnt=%0d required %0d", bubble_cnt, CNT_MAX);
    end
    hazard_dec = 0;
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_load_use();
    test_bypass();
    test_freeze();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_latch.md
Name: id_ex_latch

Overview:
- Decode→execute pipeline register of the 5-stage pipelined MIPS core.
- Sits directly downstream of the hazard unit and consumes its decode-side outputs:
  - `hazard_dec` is a load-use stall; the latch inserts a bubble.
  - `rport_dec` is a same-cycle writeback bypass; the latch replaces stale register-file reads with the memory-stage write data.
- Also handles branch/jump flush and global freeze on cache miss.
- Keeps a saturating bubble counter for performance analysis.

Parameters:
- WORD_W, 32, data/PC width
- REG_W, 5, register select width (matches `regbits_t`)
- CNT_W, 16, bubble counter width

Ports:
- CLK  input  1  core clock
- nRST  input  1  asynchronous active-low reset
- en  input  1  pipeline advance (ihit & ~dstall); 0 freezes the latch
- flush  input  1  branch/jump taken; squash the decode instruction
- hazard_dec  input  1  load-use hazard from hazard unit
- rport_dec  input  2  bit0: bypass operand 1; bit1: bypass operand 2
- wdat_mem  input  WORD_W  memory-stage writeback data
- d_valid  input  1  decode slot holds a real instruction
- d_ctrl  input  `ctrl_t`  decoded control bundle (aluop, alusrc, regwen, dren, dwen, memtoreg, halt)
- d_rsel1, d_rsel2, d_wsel  input  REG_W each  register selects
- d_rdat1, d_rdat2  input  WORD_W each  register file read data
- d_imm  input  WORD_W  extended immediate
- d_npc  input  WORD_W  PC+4
- e_valid  output  1  execute slot valid
- e_ctrl  output  `ctrl_t`  latched control
- e_rsel1, e_rsel2, e_wsel  output  REG_W  latched selects (feed `rsel1_ex`, `rsel2_ex`, `wsel_ex`)
- e_rdat1, e_rdat2, e_imm, e_npc  output  WORD_W  latched operands
- bubble_cnt  output  CNT_W  bubbles inserted since reset, saturating

Behaviour:
- Reset (nRST=0, asynchronous):
  - All outputs go to 0, so `e_valid`=0 and `e_ctrl` is all-zero (a NOP: no regwen, dren, dwen or halt).
  - `bubble_cnt`=0.
  - Reset asserted mid-stream discards the in-flight instruction; no partial state survives.
- Rising CLK, evaluated in priority order:
  1. en=0: hold every register, including `bubble_cnt`. `flush`, `hazard_dec` and `rport_dec` are ignored.
  2. en=1 & flush=1: load a bubble. `flush` wins over `hazard_dec`.
  3. en=1 & hazard_dec=1: load a bubble. The upstream IF/ID latch holds, which is not this block's concern.
  4. en=1 otherwise: capture the decode fields, `e_valid`=`d_valid`.
- Bubble definition:
  - `e_valid`=0, `e_ctrl` all-zero, `e_wsel`=0, `e_rsel1`=`e_rsel2`=0, data fields 0.
  - Guarantees that the hazard unit sees `wsel_ex`=0, so no false hazards.
- Bubble counter:
  - Increments on every bubble load (cases 2 and 3) only when `d_valid`=1 or `hazard_dec`=1; flushing an already-invalid slot does not count.
  - Saturates at 2^CNT_W−1 and never wraps.
- Bypass on capture:
  - `e_rdat1` = `rport_dec[0]` ? `wdat_mem` : `d_rdat1`; `e_rdat2` likewise with bit1.
  - Both bits may be set in the same cycle.
  - A bypass whose `d_rsel`=0 is still honoured; suppressing $0 forwarding is the hazard unit's job.
- Latency: exactly one cycle from decode inputs to `e_*` outputs when en=1.
- No combinational path from any input to any output.

Decomposition:
- `ctrl_t` packed struct (aluop_t aluop, alusrc, regwen, dren, dwen, memtoreg, halt) goes in `cpu_types_pkg`, reused by the EX/MEM latch.
- `id_ex_t` packed struct bundling all latched fields also goes in `cpu_types_pkg`, with a `BUBBLE_ID_EX` constant equal to all-zero.
- One sub-module: `sat_counter`, a parameterised saturating counter, reused by later performance counters.

Test Plan:
- Reset: nRST=0 mid-run with `e_valid`=1 → all outputs 0 immediately, without waiting for CLK; `bubble_cnt`=0.
- Normal capture: en=1, `d_rdat1`=0x1234, `d_wsel`=5, `d_valid`=1 → next edge `e_rdat1`=0x1234, `e_wsel`=5, `e_valid`=1.
- Load-use: `hazard_dec`=1 for 1 cycle with en=1 → `e_valid`=0, `e_wsel`=0, `e_ctrl.regwen`=0; `bubble_cnt` 0→1; next cycle with `hazard_dec`=0 captures the held instruction.
- Bypass: `rport_dec`=2'b11, `wdat_mem`=0xDEADBEEF, `d_rdat1`=1, `d_rdat2`=2 → `e_rdat1`=`e_rdat2`=0xDEADBEEF; `rport_dec`=2'b01 → only `e_rdat1` bypassed.
- Freeze priority: en=0 with `flush`=1 and `hazard_dec`=1 → all outputs and `bubble_cnt` unchanged; then en=1, `flush`=1, `hazard_dec`=1 → one bubble, `bubble_cnt`+1.
- Saturation: force 2^CNT_W+3 hazard cycles → `bubble_cnt` stops at 0xFFFF and does not wrap.
